// File: rtl/sdram_read_pkg.sv
// sdram_read_pkg: shared FSM encoding and word sizing helper for the SDRAM stream reader.
package sdram_read_pkg;
   typedef enum logic [1:0] {IDLE, GO, FETCH, DRAIN} state_t;
   function automatic int bytes_per_word(input int data_w);
      return data_w / 8;
   endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: first-word fall-through FIFO; a push while full is accepted only alongside a pop.
module sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0] wp, rp;
   logic do_push, do_pop;
   assign level = wp - rp;
   assign empty = level == '0;
   assign full = level == (AW+1)'(DEPTH);
   assign do_pop = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rdata = mem[rp[AW-1:0]];
   always_ff @(posedge clk) begin
      if (do_push) mem[wp[AW-1:0]] <= wdata;
   end
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wp <= '0;
         rp <= '0;
      end else begin
         if (do_push) wp <= wp + 1'b1;
         if (do_pop) rp <= rp + 1'b1;
      end
   end
endmodule

// File: rtl/sdram_stream_reader.sv
// sdram_stream_reader: streams an SDRAM byte range from a read master into a valid/ready output.
// Optional pop counter on word_count is built when SDRAM_STREAM_STATUS_EN is defined.
module sdram_stream_reader
   import sdram_read_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 32,
   parameter int FIFO_DEPTH = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start_read,
   input  logic [ADDR_W-1:0] cfg_base,
   input  logic              cfg_load,
   input  logic [ADDR_W-1:0] cfg_len,
   output logic              read_control_go,
   input  logic              read_control_done,
   input  logic              read_control_early_done,
   output logic              read_control_fixed_location,
   output logic [ADDR_W-1:0] control_read_base,
   output logic [ADDR_W-1:0] control_read_length,
   input  logic [DATA_W-1:0] user_read_buffer_data,
   input  logic              user_read_data_available,
   output logic              user_read_ack,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] word_count
);
   localparam logic [ADDR_W-1:0] LEN_MASK = ~ADDR_W'(bytes_per_word(DATA_W) - 1);
   state_t state;
   logic [ADDR_W-1:0] cur_addr, len_q, len_in;
   logic [DATA_W-1:0] head;
   logic full, empty, pop;
   logic [$clog2(FIFO_DEPTH):0] level_unused;
   logic early_unused;
   assign early_unused = read_control_early_done;
   // Lengths are whole words; any stray low bits are dropped rather than trusted.
   assign len_in = cfg_len & LEN_MASK;
   assign user_read_ack = reset_n && state == FETCH && user_read_data_available && !full;
   assign out_valid = reset_n && !empty;
   assign out_data = out_valid ? head : '0;
   assign pop = out_valid && out_ready;
   assign busy = reset_n && state != IDLE;
   assign read_control_fixed_location = 1'b0;
   assign control_read_base = cur_addr;
   assign control_read_length = len_q;

   sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk(clk),
      .reset_n(reset_n),
      .push(user_read_ack),
      .wdata(user_read_buffer_data),
      .pop(pop),
      .rdata(head),
      .full(full),
      .empty(empty),
      .level(level_unused)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state <= IDLE;
         cur_addr <= '0;
         len_q <= '0;
         read_control_go <= 1'b0;
         done <= 1'b0;
      end else begin
         read_control_go <= 1'b0;
         done <= 1'b0;
         case (state)
            IDLE: if (start_read) begin
               if (len_in == '0) done <= 1'b1;
               else begin
                  state <= GO;
                  read_control_go <= 1'b1;
                  len_q <= len_in;
                  if (cfg_load) cur_addr <= cfg_base;
               end
            end
            GO: state <= FETCH;
            FETCH: if (read_control_done && !user_read_data_available) begin
               state <= DRAIN;
               cur_addr <= cur_addr + len_q;
            end
            default: if (empty) begin
               state <= IDLE;
               done <= 1'b1;
            end
         endcase
      end
   end

`ifdef SDRAM_STREAM_STATUS_EN
   always_ff @(posedge clk) begin
      if (!reset_n) word_count <= '0;
      else if (state == IDLE && start_read && len_in != '0) word_count <= '0;
      else if (pop && word_count != '1) word_count <= word_count + 1'b1;
   end
`else
   assign word_count = '0;
`endif
endmodule

// File: tb/tb_sdram_stream_reader.sv
// tb_sdram_stream_reader: directed and randomized transfers against an address/stream reference model.
module tb_sdram_stream_reader;
   localparam int DW = 32, AW = 32, FD = 8;
`ifdef SDRAM_STREAM_STATUS_EN
   localparam bit STATUS_EN = 1'b1;
`else
   localparam bit STATUS_EN = 1'b0;
`endif
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset_n = 1'b0, start_read = 1'b0, cfg_load = 1'b0;
   logic [AW-1:0] cfg_base = '0, cfg_len = '0;
   logic read_control_go, read_control_done = 1'b0, read_control_early_done = 1'b0;
   logic read_control_fixed_location;
   logic [AW-1:0] control_read_base, control_read_length, word_count;
   logic [DW-1:0] user_read_buffer_data = '0, out_data;
   logic user_read_data_available = 1'b0, user_read_ack, out_valid, out_ready = 1'b0, busy, done;

   sdram_stream_reader #(.DATA_W(DW), .ADDR_W(AW), .FIFO_DEPTH(FD)) dut (
      .clk(clk), .reset_n(reset_n), .start_read(start_read), .cfg_base(cfg_base),
      .cfg_load(cfg_load), .cfg_len(cfg_len), .read_control_go(read_control_go),
      .read_control_done(read_control_done), .read_control_early_done(read_control_early_done),
      .read_control_fixed_location(read_control_fixed_location),
      .control_read_base(control_read_base), .control_read_length(control_read_length),
      .user_read_buffer_data(user_read_buffer_data),
      .user_read_data_available(user_read_data_available), .user_read_ack(user_read_ack),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .busy(busy), .done(done), .word_count(word_count)
   );

   logic [31:0] mem [256];
   logic [31:0] exp_q [$];
   logic [31:0] exp_addr = '0, last_base = '0, last_len = '0, m_base = '0;
   int n_chk = 0, n_fail = 0;
   int go_cnt = 0, done_cnt = 0, ack_cnt = 0, pop_cnt = 0, m_idx = 0, m_n = 0;
   int g0, d0, p0, a0, t;
   bit m_active = 1'b0, rand_avail = 1'b0, rand_ready = 1'b0;
   logic [31:0] x_len;

   function automatic logic [31:0] mem_at(input logic [31:0] a);
      return mem[a[9:2]];
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Read master model plus output monitor: drive at negedge, sample just before posedge.
   initial begin
      forever begin
         @(negedge clk);
         user_read_data_available = m_active && m_idx < m_n && (!rand_avail || $urandom_range(0, 3) != 0);
         user_read_buffer_data = mem_at(m_base + 32'(4 * m_idx));
         read_control_done = m_active && m_idx == m_n;
         if (rand_ready) out_ready = $urandom_range(0, 1) != 0;
         #4;
         if (!reset_n) begin
            m_active = 1'b0;
            m_idx = 0;
         end else begin
            if (read_control_go) begin
               go_cnt++;
               last_base = control_read_base;
               last_len = control_read_length;
               m_active = 1'b1;
               m_base = control_read_base;
               m_n = int'(control_read_length / 4);
               m_idx = 0;
            end
            if (user_read_ack) begin
               m_idx++;
               ack_cnt++;
            end
            if (done) done_cnt++;
            if (out_valid && out_ready) begin
               pop_cnt++;
               chk("pop_pending", exp_q.size() > 0, 1);
               if (exp_q.size() > 0) chk("pop_data", out_data, exp_q.pop_front());
            end
         end
      end
   end

   task automatic start_x(input logic [31:0] base, input bit load, input logic [31:0] len);
      if (load) exp_addr = base;
      x_len = len;
      for (int i = 0; i < int'(len / 4); i++) exp_q.push_back(mem_at(exp_addr + 32'(4 * i)));
      @(negedge clk);
      g0 = go_cnt; d0 = done_cnt; p0 = pop_cnt; a0 = ack_cnt;
      start_read = 1'b1; cfg_base = base; cfg_load = load; cfg_len = len;
      @(negedge clk);
      start_read = 1'b0;
   endtask

   task automatic finish_x(input string tag);
      t = 0;
      while (done_cnt == d0 && t < 3000) begin
         @(negedge clk);
         t++;
      end
      chk({tag, "_timeout"}, t < 3000, 1);
      repeat (3) @(negedge clk);
      chk({tag, "_go_cnt"}, go_cnt - g0, 1);
      chk({tag, "_base"}, last_base, exp_addr);
      chk({tag, "_len"}, last_len, x_len);
      chk({tag, "_done_cnt"}, done_cnt - d0, 1);
      chk({tag, "_pops"}, pop_cnt - p0, x_len / 4);
      chk({tag, "_leftover"}, exp_q.size(), 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_word_count"}, word_count, STATUS_EN ? x_len / 4 : 0);
      exp_addr = exp_addr + x_len;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = $urandom;
      repeat (3) @(negedge clk);
      chk("rst_go", read_control_go, 0);
      chk("rst_ack", user_read_ack, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_data", out_data, 0);
      chk("rst_wc", word_count, 0);
      chk("rst_fixed", read_control_fixed_location, 0);
      reset_n = 1'b1;
      out_ready = 1'b1;

      start_x(32'h100, 1, 16);
      finish_x("t1");
      start_x(32'h0, 0, 16);
      finish_x("t2");
      chk("t2_base_abs", last_base, 32'h110);

      @(negedge clk);
      d0 = done_cnt; g0 = go_cnt;
      start_read = 1'b1; cfg_load = 1'b1; cfg_base = 32'h5550; cfg_len = 0;
      @(negedge clk);
      start_read = 1'b0;
      chk("zl_done_early", done_cnt - d0, 0);
      chk("zl_busy", busy, 0);
      @(negedge clk);
      chk("zl_done_pulse", done_cnt - d0, 1);
      repeat (3) @(negedge clk);
      chk("zl_done_once", done_cnt - d0, 1);
      chk("zl_no_go", go_cnt - g0, 0);

      out_ready = 1'b0;
      start_x(32'h200, 1, 48);
      repeat (30) @(negedge clk);
      chk("bp_acks", ack_cnt - a0, 8);
      chk("bp_valid", out_valid, 1);
      a0 = ack_cnt;
      repeat (5) @(negedge clk);
      chk("bp_ack_low", ack_cnt - a0, 0);
      out_ready = 1'b1;
      finish_x("bp");

      start_x(32'hFFFF_FFE0, 1, 16);
      finish_x("wrap_a");
      start_x(32'h0, 0, 32);
      finish_x("wrap_b");
      start_x(32'h0, 0, 16);
      finish_x("wrap_c");
      chk("wrap_base_abs", last_base, 32'h10);

      rand_avail = 1'b1;
      rand_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         start_x($urandom & 32'hFFFF_FFFC, $urandom_range(0, 1) != 0,
                 32'(4 * (k == 2 ? 40 : $urandom_range(1, 40))));
         if (k == 2) begin
            repeat (2) @(negedge clk);
            start_read = 1'b1; cfg_load = 1'b1; cfg_base = 32'hDEAD_0000; cfg_len = 16;
            @(negedge clk);
            start_read = 1'b0;
         end
         finish_x("rnd");
      end
      rand_ready = 1'b0;
      rand_avail = 1'b0;
      @(negedge clk);
      out_ready = 1'b0;

      start_x(32'h300, 1, 32);
      t = 0;
      while (ack_cnt - a0 < 3 && t < 100) begin
         @(negedge clk);
         t++;
      end
      chk("mid_reach_3", ack_cnt - a0, 3);
      reset_n = 1'b0;
      exp_q.delete();
      @(negedge clk);
      chk("mid_valid", out_valid, 0);
      chk("mid_busy", busy, 0);
      chk("mid_data", out_data, 0);
      chk("mid_go", read_control_go, 0);
      reset_n = 1'b1;
      out_ready = 1'b1;
      exp_addr = 32'h0;
      start_x(32'h0, 0, 16);
      finish_x("post_rst");
      chk("post_rst_base_abs", last_base, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/sdram_stream_reader.md
SDRAM_STREAM_READER -- requirements
Module: sdram_stream_reader

Interface
REQ-001 Parameter DATA_W, default 32: word width of the SDRAM read master and of the output stream; must be a multiple of 8.
REQ-002 Parameter ADDR_W, default 32: byte-address width.
REQ-003 Parameter FIFO_DEPTH, default 8: output buffer depth in words; must be a power of 2, at least 2.
REQ-004 Port clk, input, 1: single clock; all logic is on its rising edge.
REQ-005 Port reset_n, input, 1: reset, synchronous, active-low.
REQ-006 Port start_read, input, 1: transfer request; sampled only in IDLE.
REQ-007 Port cfg_base, input, ADDR_W: byte start address, used when cfg_load=1.
REQ-008 Port cfg_load, input, 1: 1 loads cfg_base at start; 0 continues from the previous end address.
REQ-009 Port cfg_len, input, ADDR_W: transfer length in bytes; must be a multiple of DATA_W/8.
REQ-010 Ports read_control_go (output, 1), read_control_done (input, 1), read_control_early_done (input, 1), read_control_fixed_location (output, 1): read master control signals.
REQ-011 Ports control_read_base (output, ADDR_W) and control_read_length (output, ADDR_W): transfer base and length driven to the master.
REQ-012 Ports user_read_buffer_data (input, DATA_W), user_read_data_available (input, 1), user_read_ack (output, 1): show-ahead read buffer pop interface.
REQ-013 Ports out_data (output, DATA_W), out_valid (output, 1), out_ready (input, 1): output stream to the SPI block.
REQ-014 Ports busy (output, 1), done (output, 1): status signals; done is a one-cycle pulse.

Function
REQ-015 States SHALL be IDLE, GO, FETCH and DRAIN.
REQ-016 IDLE -> GO on start_read=1 with cfg_len != 0; cur_addr <= cfg_base if cfg_load=1, else cur_addr is kept; cfg_len is latched into len_q.
REQ-017 start_read=1 with cfg_len=0 SHALL stay in IDLE, assert no read_control_go, and pulse done the next cycle.
REQ-018 GO SHALL assert read_control_go for exactly one cycle with control_read_base=cur_addr and control_read_length=len_q, then go to FETCH.
REQ-019 user_read_ack SHALL be combinational: high only when in FETCH, user_read_data_available=1 and the FIFO is not full; on the same edge, user_read_buffer_data is written to the FIFO.
REQ-020 FETCH -> DRAIN once read_control_done=1 and user_read_data_available=0 in the same cycle; read_control_early_done is ignored.
REQ-021 On the FETCH -> DRAIN transition, cur_addr SHALL advance to cur_addr+len_q, wrapping modulo 2^ADDR_W.
REQ-022 DRAIN -> IDLE when the FIFO is empty; done pulses for 1 cycle on entering IDLE.
REQ-023 The output SHALL be valid/ready: out_valid = FIFO not empty; out_data = FIFO head (first-word fall-through); a word is popped when out_valid and out_ready are both high.
REQ-024 Simultaneous push and pop SHALL be legal when the FIFO is full or empty; the level is then unchanged, except when empty, where the pushed word appears at the head the next cycle.
REQ-025 busy SHALL be 1 in every state except IDLE.
REQ-026 read_control_fixed_location SHALL be constant 0 (incrementing addresses).
REQ-027 start_read asserted while busy SHALL be ignored; there is no queuing.

Reset
REQ-028 reset_n=0 at a clock edge SHALL force IDLE and set cur_addr=0, len_q=0 and the FIFO empty.
REQ-029 During reset, read_control_go, user_read_ack, out_valid, busy and done SHALL be 0, and out_data SHALL be 0.
REQ-030 Reset during a transfer SHALL discard buffered words; the master is expected to be reset by the same reset.

Configuration
REQ-031 With SDRAM_STREAM_STATUS_EN defined: output word_count [ADDR_W-1:0] SHALL count output pops since the last start; it clears on leaving IDLE and saturates at all-ones.
REQ-032 Without SDRAM_STREAM_STATUS_EN: the word_count port is still present and tied to 0, and no counter logic is built.

Structure
REQ-033 Package sdram_read_pkg SHALL hold the state enum and the function bytes_per_word(DATA_W).
REQ-034 The FIFO SHALL be the sub-module sync_fifo (parameters WIDTH and DEPTH; outputs full, empty and level).

Verification
REQ-035 cfg_base=0x100, cfg_load=1, cfg_len=16, out_ready=1 -> one go pulse with base 0x100 and length 16; 4 words out in order; done pulses once.
REQ-036 Repeat start with cfg_load=0, cfg_len=16 -> go with base 0x110.
REQ-037 out_ready=0, 12 words available, FIFO_DEPTH=8 -> exactly 8 acks, then ack stays low until out_ready=1; no word lost or duplicated.
REQ-038 cfg_len=0 -> no go pulse; done pulses one cycle after start.
REQ-039 cur_addr=0xFFFFFFF0, cfg_load=0, cfg_len=32 -> next base 0x00000010.
REQ-040 reset_n=0 mid-FETCH with 3 words buffered -> next cycle out_valid=0, busy=0, state IDLE.
